// File: rtl/neuron_pkg.sv
// Shared types and default widths for the neuron input bridge.
// The FSM walks one 4-phase req/ack handshake per sample.
package neuron_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } bridge_state_t;

  localparam int DATA_BITS_DEF = 4;
  localparam int CNT_BITS_DEF  = 16;

endpackage

// File: rtl/neuron_bridge_fifo.sv
// Small synchronous sample FIFO with occupancy count. Push is refused while full,
// even if a pop happens in the same cycle; pop is ignored while empty.
module neuron_bridge_fifo #(
  parameter int data_bits  = 4,
  parameter int fifo_depth = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [data_bits-1:0]          wdata,
  output logic [data_bits-1:0]          rdata,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(fifo_depth):0]   count
);

  localparam int ptr_bits = $clog2(fifo_depth);
  localparam logic [ptr_bits-1:0] ptr_one  = ptr_bits'(1);
  localparam logic [ptr_bits:0]   cnt_one  = (ptr_bits + 1)'(1);
  localparam logic [ptr_bits:0]   cnt_full = (ptr_bits + 1)'(fifo_depth);

  logic [data_bits-1:0] mem [fifo_depth];
  logic [ptr_bits-1:0]  wr_ptr_reg;
  logic [ptr_bits-1:0]  rd_ptr_reg;
  logic [ptr_bits:0]    count_reg;
  logic                 push_ok;
  logic                 pop_ok;

  assign full    = (count_reg == cnt_full);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign push_ok = push & !full;
  assign pop_ok  = pop & !empty;
  assign rdata   = mem[rd_ptr_reg];

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + ptr_one;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + ptr_one;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + cnt_one;
        2'b01:   count_reg <= count_reg - cnt_one;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/neuron_input_bridge.sv
// Buffers valid/ready samples and delivers each one to a neuron over its
// asynchronous 4-phase req/ack channel; ack is brought in through a flop chain.
module neuron_input_bridge
  import neuron_pkg::*;
#(
  parameter int data_bits   = DATA_BITS_DEF,
  parameter int fifo_depth  = 4,
  parameter int sync_stages = 2,
  parameter int cnt_bits    = CNT_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [data_bits-1:0] in_data,
  output logic [data_bits-1:0] data_out,
  output logic                 req_out,
  input  logic                 ack_in,
  output logic [cnt_bits-1:0]  sent_cnt,
  output logic                 busy
);

  localparam logic [cnt_bits-1:0] sent_one = cnt_bits'(1);

  bridge_state_t                state_reg;
  bridge_state_t                state_next;
  logic                         req_reg;
  logic                         req_next;
  logic [data_bits-1:0]         data_reg;
  logic [cnt_bits-1:0]          sent_cnt_reg;
  logic                         pop;
  logic                         cnt_inc;
  logic                         ack_s;
  logic [data_bits-1:0]         fifo_rdata;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [$clog2(fifo_depth):0]  fifo_count;

  // CDC: ack_in is asynchronous to clk; plain flop chain, nothing else reads ack_in.
  logic [sync_stages-1:0] ack_sync_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_sync_reg <= '0;
    end else begin
      ack_sync_reg <= {ack_sync_reg[sync_stages-2:0], ack_in};
    end
  end

  assign ack_s = ack_sync_reg[sync_stages-1];

  neuron_bridge_fifo #(
    .data_bits  (data_bits),
    .fifo_depth (fifo_depth)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (pop),
    .wdata (in_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_next = state_reg;
    req_next   = req_reg;
    pop        = 1'b0;
    cnt_inc    = 1'b0;
    case (state_reg)
      // A still-high ack (post-reset or bypassed neuron) blocks a new launch.
      IDLE: begin
        if (!fifo_empty && !ack_s) begin
          pop        = 1'b1;
          req_next   = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (ack_s) begin
          req_next   = 1'b0;
          state_next = REL;
        end
      end
      REL: begin
        if (!ack_s) begin
          cnt_inc    = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        req_next   = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      req_reg      <= 1'b0;
      data_reg     <= '0;
      sent_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      req_reg   <= req_next;
      if (pop) begin
        data_reg <= fifo_rdata;
      end
      if (cnt_inc) begin
        sent_cnt_reg <= sent_cnt_reg + sent_one;
      end
    end
  end

  assign in_ready = !fifo_full;
  assign req_out  = req_reg;
  assign data_out = data_reg;
  assign sent_cnt = sent_cnt_reg;
  assign busy     = (fifo_count != '0) | (state_reg != IDLE);

endmodule

// File: tb/tb_neuron_input_bridge.sv
// Scoreboard bench for neuron_input_bridge with a behavioural neuron ack responder.
module tb_neuron_input_bridge;

  localparam int DB = 4;
  localparam int FD = 4;
  localparam int SS = 2;
  localparam int CB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DB-1:0] in_data = '0;
  logic [DB-1:0] data_out;
  logic          req_out;
  logic          ack_in = 1'b0;
  logic [CB-1:0] sent_cnt;
  logic          busy;

  int            vectors = 0;
  int            miscompares = 0;
  logic [DB-1:0] exp_q[$];
  bit            auto_ack = 1'b0;

  neuron_input_bridge #(
    .data_bits   (DB),
    .fifo_depth  (FD),
    .sync_stages (SS),
    .cnt_bits    (CB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .data_out (data_out),
    .req_out  (req_out),
    .ack_in   (ack_in),
    .sent_cnt (sent_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Neuron model: ack follows req about 2-3 ns later when enabled.
  always begin
    #1;
    if (auto_ack && (ack_in !== req_out)) begin
      #2;
      ack_in = req_out;
    end
  end

  task automatic drive_push(input logic [DB-1:0] d, output bit accepted);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    accepted = in_ready;
    if (accepted) exp_q.push_back(d);
    $display("push data=%h accepted=%0d", d, accepted);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_req(input logic level, input string name);
    int n = 0;
    while (req_out !== level && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (req_out !== level) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout: req_out=%b required %b", name, req_out, level);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout: busy=%b required 0", name, busy);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({req_out, data_out, in_ready, sent_cnt, busy} !== {1'b0, 4'h0, 1'b1, 4'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_values: req=%b data=%h ready=%b cnt=%0d busy=%b required 0 0 1 0 0",
               req_out, data_out, in_ready, sent_cnt, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    bit acc;
    logic [DB-1:0] e;
    auto_ack = 1'b1;
    drive_push(4'h9, acc);
    @(negedge clk);
    vectors++;
    if (req_out !== 1'b0) begin
      miscompares++;
      $display("FAIL single_req_early: req_out=%b required 0", req_out);
    end
    @(negedge clk);
    vectors++;
    if (req_out !== 1'b1) begin
      miscompares++;
      $display("FAIL single_req_rise: req_out=%b required 1", req_out);
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    vectors++;
    if (data_out !== e) begin
      miscompares++;
      $display("FAIL single_data: data_out=%h required %h", data_out, e);
    end
    $display("deliver single data_out=%h expected=%h", data_out, e);
    repeat (2) @(negedge clk);
    vectors++;
    if (req_out !== 1'b1) begin
      miscompares++;
      $display("FAIL single_req_hold: req_out=%b required 1", req_out);
    end
    @(negedge clk);
    vectors++;
    if ({req_out, data_out} !== {1'b0, 4'h9}) begin
      miscompares++;
      $display("FAIL single_release: req=%b data=%h required 0 9", req_out, data_out);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (sent_cnt !== 4'd0) begin
      miscompares++;
      $display("FAIL single_cnt_early: sent_cnt=%0d required 0", sent_cnt);
    end
    @(negedge clk);
    vectors++;
    if ({sent_cnt, busy} !== {4'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL single_done: sent_cnt=%0d busy=%b required 1 0", sent_cnt, busy);
    end
  endtask

  task automatic test_back_to_back();
    bit acc;
    logic [DB-1:0] e;
    auto_ack = 1'b0;
    ack_in   = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      drive_push(DB'(i), acc);
      vectors++;
      if (acc !== (i <= 5)) begin
        miscompares++;
        $display("FAIL b2b_accept_%0d: in_ready=%b required %b", i, acc, (i <= 5));
      end
    end
    @(negedge clk);
    vectors++;
    if ({req_out, busy} !== 2'b11) begin
      miscompares++;
      $display("FAIL b2b_req_held: req=%b busy=%b required 1 1", req_out, busy);
    end
    auto_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_req(1'b1, "b2b_req");
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      vectors++;
      if (data_out !== e) begin
        miscompares++;
        $display("FAIL b2b_order_%0d: data_out=%h required %h", k, data_out, e);
      end
      $display("deliver b2b data_out=%h expected=%h", data_out, e);
      wait_req(1'b0, "b2b_rel");
    end
    wait_idle("b2b_idle");
    vectors++;
    if (sent_cnt !== 4'd6) begin
      miscompares++;
      $display("FAIL b2b_count: sent_cnt=%0d required 6", sent_cnt);
    end
  endtask

  task automatic test_full_pop();
    bit acc;
    bit prev_ready;
    logic [DB-1:0] e;
    auto_ack = 1'b0;
    ack_in   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_push(DB'(10 + i), acc);
      vectors++;
      if (acc !== 1'b1) begin
        miscompares++;
        $display("FAIL fp_accept_%0d: in_ready=%b required 1", i, acc);
      end
    end
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL fp_full: in_ready=%b required 0", in_ready);
    end
    in_valid = 1'b1;
    in_data  = 4'h5;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    vectors++;
    if (data_out !== e) begin
      miscompares++;
      $display("FAIL fp_first: data_out=%h required %h", data_out, e);
    end
    $display("deliver fp data_out=%h expected=%h", data_out, e);
    ack_in = 1'b1;
    wait_req(1'b0, "fp_rel");
    ack_in = 1'b0;
    prev_ready = in_ready;
    for (int n = 0; n < 20 && req_out !== 1'b1; n++) begin
      prev_ready = in_ready;
      @(negedge clk);
    end
    vectors++;
    if ({prev_ready, in_ready, req_out} !== 3'b011) begin
      miscompares++;
      $display("FAIL fp_pop_cycle: ready_before=%b ready_after=%b req=%b required 0 1 1",
               prev_ready, in_ready, req_out);
    end
    exp_q.push_back(4'h5);
    $display("push data=5 accepted=1");
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL fp_refill: in_ready=%b required 0", in_ready);
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    vectors++;
    if (data_out !== e) begin
      miscompares++;
      $display("FAIL fp_second: data_out=%h required %h", data_out, e);
    end
    $display("deliver fp data_out=%h expected=%h", data_out, e);
    auto_ack = 1'b1;
    wait_req(1'b0, "fp_rel2");
    for (int k = 0; k < 4; k++) begin
      wait_req(1'b1, "fp_req");
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      vectors++;
      if (data_out !== e) begin
        miscompares++;
        $display("FAIL fp_order_%0d: data_out=%h required %h", k, data_out, e);
      end
      $display("deliver fp data_out=%h expected=%h", data_out, e);
      wait_req(1'b0, "fp_rel");
    end
    wait_idle("fp_idle");
    vectors++;
    if (sent_cnt !== 4'd12) begin
      miscompares++;
      $display("FAIL fp_count: sent_cnt=%0d required 12", sent_cnt);
    end
  endtask

  task automatic test_ack_at_reset();
    bit acc;
    bit seen_req;
    logic [DB-1:0] e;
    auto_ack = 1'b0;
    @(negedge clk);
    rst    = 1'b0;
    ack_in = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    drive_push(4'h3, acc);
    drive_push(4'h7, acc);
    seen_req = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (req_out !== 1'b0) seen_req = 1'b1;
    end
    vectors++;
    if (seen_req !== 1'b0) begin
      miscompares++;
      $display("FAIL ackrst_blocked: req_out seen=%b required 0", seen_req);
    end
    ack_in = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (req_out !== 1'b0) begin
      miscompares++;
      $display("FAIL ackrst_sync: req_out=%b required 0", req_out);
    end
    @(negedge clk);
    vectors++;
    if (req_out !== 1'b1) begin
      miscompares++;
      $display("FAIL ackrst_launch: req_out=%b required 1", req_out);
    end
    auto_ack = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_req(1'b1, "ackrst_req");
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      vectors++;
      if (data_out !== e) begin
        miscompares++;
        $display("FAIL ackrst_data_%0d: data_out=%h required %h", k, data_out, e);
      end
      $display("deliver ackrst data_out=%h expected=%h", data_out, e);
      wait_req(1'b0, "ackrst_rel");
    end
    wait_idle("ackrst_idle");
    vectors++;
    if (sent_cnt !== 4'd2) begin
      miscompares++;
      $display("FAIL ackrst_count: sent_cnt=%0d required 2", sent_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit acc;
    bit seen_req;
    auto_ack = 1'b0;
    ack_in   = 1'b0;
    for (int i = 0; i < 4; i++) drive_push(DB'(12 + i), acc);
    @(negedge clk);
    vectors++;
    if ({req_out, data_out} !== {1'b1, 4'hC}) begin
      miscompares++;
      $display("FAIL mid_in_req: req=%b data=%h required 1 c", req_out, data_out);
    end
    exp_q.delete();
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({req_out, data_out, in_ready, sent_cnt, busy} !== {1'b0, 4'h0, 1'b1, 4'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL mid_async_reset: req=%b data=%h ready=%b cnt=%0d busy=%b required 0 0 1 0 0",
               req_out, data_out, in_ready, sent_cnt, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    auto_ack = 1'b1;
    seen_req = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (req_out !== 1'b0 || busy !== 1'b0) seen_req = 1'b1;
    end
    vectors++;
    if (seen_req !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_flushed: activity seen=%b required 0", seen_req);
    end
  endtask

  task automatic test_wrap();
    bit acc;
    logic [DB-1:0] e;
    auto_ack = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive_push(DB'(i), acc);
      wait_req(1'b1, "wrap_req");
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      vectors++;
      if (data_out !== e) begin
        miscompares++;
        $display("FAIL wrap_data_%0d: data_out=%h required %h", i, data_out, e);
      end
      $display("deliver wrap data_out=%h expected=%h", data_out, e);
      wait_req(1'b0, "wrap_rel");
    end
    wait_idle("wrap_idle");
    vectors++;
    if (sent_cnt !== 4'd1) begin
      miscompares++;
      $display("FAIL wrap_count: sent_cnt=%0d required 1", sent_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_pop();
    test_ack_at_reset();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
